mux_operand_loader: RTL and testbench
=====================================

Name: mux_operand_loader

Overview:
- Upstream front-end for the N-bit 2:1 operand mux: captures two operands from the slide switches and generates the mux select from push-buttons.
- Raw board keys are synchronised and debounced; one-cycle press pulses drive a small load FSM.
- The FSM loads operand x, then operand y, from the switches.
- Registered x, y and s feed the mux inputs directly; ready and state drive the spare LEDs.

Parameters:
- N, 4, operand width; matches the mux width.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key change (10 ms at 50 MHz). Must be ≥2. The bench overrides it to 4.

Ports:
- CLOCK_50  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- SW  input  N  operand value from the slide switches.
- KEY_load  input  1  raw load push-button, active-low (0 = pressed), asynchronous to the clock.
- KEY_sel  input  1  raw select push-button, active-low, asynchronous to the clock.
- x  output  N  registered operand A, to the mux x input.
- y  output  N  registered operand B, to the mux y input.
- s  output  1  registered select, to the mux s input.
- ready  output  1  high while both operands hold valid values (state READY).
- state  output  2  current FSM encoding, for LED display.

Behaviour:
- Reset (resetn=0, acts immediately, no clock required):
  - x=0, y=0, s=0, ready=0, state=LOAD_X.
  - Synchroniser flops = 1; debounced key levels = 1 (released).
  - Debounce counters = 0; press pulses = 0.
- Reset asserted mid-debounce or mid-load discards all progress. No partial operand survives.
- Synchronisation: each KEY passes through a 2-flop synchroniser before any other use.
- Debounce, per key, independent:
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)).
  - On each edge where the synchronised level differs from the debounced level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 on such an edge, the debounced level takes the synchronised value and the counter clears.
  - Any edge where the synchronised level equals the debounced level clears the counter, so bounces shorter than DEBOUNCE_CYCLES are rejected.
- Press pulse:
  - Registered, high for exactly one cycle, on the edge where the debounced level goes 1→0.
  - Release (0→1) generates no pulse.
  - A held key produces exactly one pulse.
- Latency: with raw KEY low and stable from edge k onward, the press pulse is high after edge k+1+DEBOUNCE_CYCLES (±1 for asynchronous sampling). The resulting output update occurs on the following edge.
- FSM (encoding LOAD_X=2'b00, LOAD_Y=2'b01, READY=2'b10; 2'b11 unreachable, recovers to LOAD_X on next edge):
  - LOAD_X + load pulse: x<=SW, go to LOAD_Y.
  - LOAD_Y + load pulse: y<=SW, go to READY.
  - READY + load pulse: x<=SW, go to LOAD_Y. y keeps its old value; ready falls.
  - No load pulse: state, x and y hold.
- ready = (state==READY), registered with the state.
- Select: a sel pulse toggles s in every state. s is independent of the FSM and of ready.
- Simultaneous load and sel pulses on the same edge: both actions take effect on that edge.
- SW is sampled only on the edge consuming a load pulse; SW changes at any other time have no effect.
- SW is a quasi-static input and is not synchronised.
- Outputs are glitch-free registers; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then release with all keys high → x=0, y=0, s=0, ready=0, state=00. Assert resetn=0 mid-sequence → outputs return to these values without a clock edge.
2. DEBOUNCE_CYCLES=4. SW=4'hA, hold KEY_load low 10 cycles → x=4'hA within 8 edges, state=01. Release; SW=4'h5; press again → y=4'h5, state=10, ready=1.
3. Bounce: toggle KEY_load low/high every 2 cycles for 20 cycles, then hold high → no pulse; x, y and state unchanged.
4. Hold KEY_load low for 100 cycles → exactly one load action; state advances by one step only.
5. In READY with x=A, y=5: SW=4'h3, press load → x=3, y stays 5, state=01, ready=0. Press KEY_sel 3 times → s=1, 0, 1 in turn.
6. Press KEY_load and KEY_sel at the same cycle from LOAD_Y with SW=4'hC → on the same edge y=4'hC, state=10 and s toggles.

Source files
------------

// File: rtl/mux_operand_loader.sv
// mux_operand_loader: captures two N-bit operands from the slide switches
// and produces the mux select from push-buttons. Each raw key is
// synchronised and debounced, and its press pulses drive a small load FSM.
module mux_operand_loader #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  input  logic [N-1:0] SW,
  input  logic         KEY_load,
  input  logic         KEY_sel,
  output logic [N-1:0] x,
  output logic [N-1:0] y,
  output logic         s,
  output logic         ready,
  output logic [1:0]   state
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam int K_LOAD = 0;
  localparam int K_SEL  = 1;

  typedef enum logic [1:0] {
    LOAD_X = 2'b00,
    LOAD_Y = 2'b01,
    READY  = 2'b10
  } state_e;

  // Key channel 0 is load, channel 1 is select; both are active-low.
  logic [1:0]    sync1_d, sync1_q, sync2_d, sync2_q;
  logic [1:0]    deb_d, deb_q;
  logic [1:0]    pulse_d, pulse_q;
  logic [CW-1:0] cnt_d [2];
  logic [CW-1:0] cnt_q [2];

  state_e        state_d, state_q;
  logic [N-1:0]  x_d, x_q, y_d, y_q;
  logic          s_d, s_q, ready_d, ready_q;

  // Two-flop synchroniser inputs: raw keys in, first stage forwarded.
  always_comb begin
    sync1_d = {KEY_sel, KEY_load};
    sync2_d = sync1_q;
  end

  // Per-key debounce counter and falling-edge press detection.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      deb_d[k] = deb_q[k];
      cnt_d[k] = cnt_q[k];
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          deb_d[k] = sync2_q[k];
          cnt_d[k] = {CW{1'b0}};
        end else begin
          cnt_d[k] = cnt_q[k] + {{(CW-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_d[k] = {CW{1'b0}};
      end
      // Pulse only on released -> pressed; release is ignored.
      pulse_d[k] = deb_q[k] & ~deb_d[k];
    end
  end

  // Load FSM plus independent select toggle; both may act on one edge.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    s_d     = s_q;
    if (pulse_q[K_SEL]) begin
      s_d = ~s_q;
    end else begin
      s_d = s_q;
    end
    case (state_q)
      LOAD_X: begin
        if (pulse_q[K_LOAD]) begin
          x_d     = SW;
          state_d = LOAD_Y;
        end else begin
          state_d = LOAD_X;
        end
      end
      LOAD_Y: begin
        if (pulse_q[K_LOAD]) begin
          y_d     = SW;
          state_d = READY;
        end else begin
          state_d = LOAD_Y;
        end
      end
      READY: begin
        // Reload restarts at x; y keeps its old value until overwritten.
        if (pulse_q[K_LOAD]) begin
          x_d     = SW;
          state_d = LOAD_Y;
        end else begin
          state_d = READY;
        end
      end
      default: begin
        state_d = LOAD_X;
      end
    endcase
    ready_d = (state_d == READY);
  end

  // Synchroniser, debounce and pulse registers; keys reset to released.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      pulse_q <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= {CW{1'b0}};
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      pulse_q <= pulse_d;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // FSM state and operand/select output registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= LOAD_X;
      x_q     <= {N{1'b0}};
      y_q     <= {N{1'b0}};
      s_q     <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
      ready_q <= ready_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign s     = s_q;
  assign ready = ready_q;
  assign state = state_q;

endmodule

// File: tb/tb_mux_operand_loader.sv
// Directed bench for mux_operand_loader with a short debounce window.
module tb_mux_operand_loader;

  logic       CLOCK_50;
  logic       resetn;
  logic [3:0] SW;
  logic       KEY_load;
  logic       KEY_sel;
  logic [3:0] x;
  logic [3:0] y;
  logic       s;
  logic       ready;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  mux_operand_loader #(.N(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .SW       (SW),
    .KEY_load (KEY_load),
    .KEY_sel  (KEY_sel),
    .x        (x),
    .y        (y),
    .s        (s),
    .ready    (ready),
    .state    (state)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] ex, input logic [3:0] ey,
                           input logic es, input logic er, input logic [1:0] est);
    checks++;
    if ({x, y, s, ready, state} !== {ex, ey, es, er, est}) begin
      errors++;
      $display("FAIL %s: got x=%h y=%h s=%b ready=%b state=%b, expected x=%h y=%h s=%b ready=%b state=%b",
               name, x, y, s, ready, state, ex, ey, es, er, est);
    end
  endtask

  // Press load for 'hold' cycles, then release long enough to re-debounce.
  task automatic press_load(input int hold);
    KEY_load = 1'b0;
    tick(hold);
    KEY_load = 1'b1;
    tick(10);
  endtask

  task automatic press_sel(input int hold);
    KEY_sel = 1'b0;
    tick(hold);
    KEY_sel = 1'b1;
    tick(10);
  endtask

  task automatic test_reset;
    resetn = 1'b0; SW = 4'h0; KEY_load = 1'b1; KEY_sel = 1'b1;
    tick(3);
    check_all("reset_held", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    resetn = 1'b1;
    tick(5);
    check_all("reset_released", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_load_xy;
    bit found;
    SW = 4'hA;
    KEY_load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (x === 4'hA) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL load_x_latency: x=%h after 8 edges, expected A", x);
    end
    tick(4);
    KEY_load = 1'b1;
    tick(10);
    check_all("load_x", 4'hA, 4'h0, 1'b0, 1'b0, 2'b01);
    SW = 4'h5;
    press_load(10);
    check_all("load_y", 4'hA, 4'h5, 1'b0, 1'b1, 2'b10);
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 5; i++) begin
      KEY_load = 1'b0;
      SW = 4'hF;
      tick(2);
      KEY_load = 1'b1;
      SW = 4'h1;
      tick(2);
    end
    tick(10);
    check_all("bounce_rejected", 4'hA, 4'h5, 1'b0, 1'b1, 2'b10);
  endtask

  task automatic test_long_hold;
    SW = 4'h9;
    KEY_load = 1'b0;
    tick(20);
    SW = 4'hF;
    tick(80);
    KEY_load = 1'b1;
    tick(10);
    check_all("long_hold_one_step", 4'h9, 4'h5, 1'b0, 1'b0, 2'b01);
    SW = 4'h5;
    press_load(8);
    check_all("restore_y", 4'h9, 4'h5, 1'b0, 1'b1, 2'b10);
    SW = 4'hA;
    press_load(8);
    check_all("restore_x", 4'hA, 4'h5, 1'b0, 1'b0, 2'b01);
    SW = 4'h5;
    press_load(8);
    check_all("restore_ready", 4'hA, 4'h5, 1'b0, 1'b1, 2'b10);
  endtask

  task automatic test_reload_and_select;
    SW = 4'h3;
    press_load(8);
    check_all("reload_x", 4'h3, 4'h5, 1'b0, 1'b0, 2'b01);
    press_sel(8);
    check_all("sel_1", 4'h3, 4'h5, 1'b1, 1'b0, 2'b01);
    press_sel(8);
    check_all("sel_2", 4'h3, 4'h5, 1'b0, 1'b0, 2'b01);
    press_sel(8);
    check_all("sel_3", 4'h3, 4'h5, 1'b1, 1'b0, 2'b01);
  endtask

  task automatic test_simultaneous;
    bit found;
    SW = 4'hC;
    KEY_load = 1'b0;
    KEY_sel = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (state !== 2'b01 || s !== 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL simul_timeout: no update within 20 edges");
    end
    check_all("simul_same_edge", 4'h3, 4'hC, 1'b0, 1'b1, 2'b10);
    KEY_load = 1'b1;
    KEY_sel = 1'b1;
    tick(10);
    check_all("simul_after", 4'h3, 4'hC, 1'b0, 1'b1, 2'b10);
  endtask

  task automatic test_async_reset;
    SW = 4'h7;
    KEY_load = 1'b0;
    tick(3);
    #2;
    resetn = 1'b0;
    #1;
    check_all("async_reset_no_clock", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    KEY_load = 1'b1;
    tick(2);
    resetn = 1'b1;
    tick(12);
    check_all("after_async_reset", 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_load_xy();
    test_bounce();
    test_long_hold();
    test_reload_and_select();
    test_simultaneous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
